// File: rtl/ofs_plat_axi_mem_lite_csr_responder.sv
`timescale 1ns/1ps
// ofs_plat_axi_mem_lite_csr_responder: AXI-Lite MMIO sink servicing a local 64-bit CSR file.
// CSR 0 is a constant ID; out-of-range accesses return SLVERR with no side effects.
module ofs_plat_axi_mem_lite_csr_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 64,
  parameter int          NUM_CSRS   = 16,
  parameter logic [63:0] CSR_ID     = 64'h0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_CSRS*DATA_WIDTH-1:0] csr_q,
  output logic                           csr_wr_valid,
  output logic [$clog2(NUM_CSRS)-1:0]    csr_wr_idx
);
  localparam int IW = ADDR_WIDTH - 3;
  localparam int XW = $clog2(NUM_CSRS);
  localparam int SW = DATA_WIDTH / 8;
  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 64");
  end
  if (NUM_CSRS < 2) begin : g_bad_count
    $error("NUM_CSRS must be at least 2");
  end
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [DATA_WIDTH-1:0] csr [NUM_CSRS];
  logic [IW-1:0] aw_idx_q, c_idx, ar_idx;
  logic [DATA_WIDTH-1:0] w_data_q, c_data;
  logic [SW-1:0] w_strb_q, c_strb;
  logic aw_fire, w_fire, ar_fire, commit, c_in_range, c_writable, ar_in_range;
  logic unused_ok;
  assign unused_ok = ^{awaddr[2:0], araddr[2:0]};
  assign aw_fire = awvalid && awready;
  assign w_fire = wvalid && wready;
  assign ar_fire = arvalid && arready;
  assign ar_idx = araddr[ADDR_WIDTH-1:3];
  assign ar_in_range = int'(ar_idx) < NUM_CSRS;
  assign c_in_range = int'(c_idx) < NUM_CSRS;
  assign c_writable = c_in_range && c_idx != '0;
  for (genvar g = 0; g < NUM_CSRS; g++) begin : g_csr_q
    assign csr_q[g*DATA_WIDTH +: DATA_WIDTH] = csr[g];
  end
  // Commit source mixes live bus fields with whichever half was latched earlier
  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    c_idx = awaddr[ADDR_WIDTH-1:3];
    c_data = wdata;
    c_strb = wstrb;
    case (w_state)
      W_IDLE: begin
        commit = aw_fire && w_fire;
        w_next = commit ? W_RESP : aw_fire ? W_HAVE_AW : w_fire ? W_HAVE_W : W_IDLE;
      end
      W_HAVE_AW: begin
        c_idx = aw_idx_q;
        commit = w_fire;
        w_next = w_fire ? W_RESP : W_HAVE_AW;
      end
      W_HAVE_W: begin
        c_data = w_data_q;
        c_strb = w_strb_q;
        commit = aw_fire;
        w_next = aw_fire ? W_RESP : W_HAVE_W;
      end
      default: w_next = bready ? W_IDLE : W_RESP;
    endcase
  end
  assign r_next = r_state == R_IDLE ? (ar_fire ? R_RESP : R_IDLE) : (rready ? R_IDLE : R_RESP);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= '0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      csr_wr_valid <= 1'b0;
      csr_wr_idx <= '0;
    end else begin
      w_state <= w_next;
      awready <= w_next == W_IDLE || w_next == W_HAVE_W;
      wready <= w_next == W_IDLE || w_next == W_HAVE_AW;
      bvalid <= w_next == W_RESP;
      csr_wr_valid <= commit && c_writable;
      if (aw_fire) aw_idx_q <= awaddr[ADDR_WIDTH-1:3];
      if (w_fire) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) bresp <= c_in_range ? 2'b00 : 2'b10;
      if (commit && c_writable) csr_wr_idx <= c_idx[XW-1:0];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CSRS; i++) csr[i] <= (i == 0) ? CSR_ID : '0;
    end else if (commit && c_writable) begin
      for (int b = 0; b < SW; b++) if (c_strb[b]) csr[c_idx[XW-1:0]][8*b +: 8] <= c_data[8*b +: 8];
    end
  end
  // Nonblocking capture sees the CSR file before any write committing on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= '0;
    end else begin
      r_state <= r_next;
      arready <= r_next == R_IDLE;
      rvalid <= r_next == R_RESP;
      if (ar_fire) begin
        rdata <= ar_in_range ? csr[ar_idx[XW-1:0]] : '0;
        rresp <= ar_in_range ? 2'b00 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_ofs_plat_axi_mem_lite_csr_responder.sv
`timescale 1ns/1ps
// tb_ofs_plat_axi_mem_lite_csr_responder: vector table plus hand sequences, responses checked
// against a scoreboard of expectations queued when each transaction is driven.
module tb_ofs_plat_axi_mem_lite_csr_responder;
  localparam logic [63:0] ID = 64'hA5A5_0000_1234_5678;
  logic clk = 1'b0, reset_n = 1'b0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic awready, wready, arready, bvalid, rvalid, csr_wr_valid;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [63:0] wdata = '0, rdata;
  logic [7:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [1023:0] csr_q;
  logic [3:0] csr_wr_idx;
  always #5 clk = ~clk;
  ofs_plat_axi_mem_lite_csr_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(64), .NUM_CSRS(16), .CSR_ID(ID)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .csr_q(csr_q), .csr_wr_valid(csr_wr_valid), .csr_wr_idx(csr_wr_idx)
  );
  typedef struct {logic [1:0] resp; logic [63:0] data; logic wv; logic [3:0] idx;} exp_t;
  typedef struct {logic wr; logic [15:0] addr; logic [63:0] data; logic [7:0] strb; logic [1:0] resp; logic [63:0] rdata; logic wv;} vec_t;
  exp_t bq[$], rq[$];
  exp_t e;
  vec_t tbl[13];
  logic [63:0] m [16];
  int checks = 0, errors = 0;
  logic bvalid_q = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m[i] = (i == 0) ? ID : 64'h0;
  endfunction
  function automatic exp_t model_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    exp_t x;
    logic [12:0] i;
    i = a[15:3];
    x.resp = i < 13'd16 ? 2'b00 : 2'b10;
    x.wv = i != 13'd0 && i < 13'd16;
    x.idx = a[6:3];
    x.data = '0;
    if (x.wv) for (int b = 0; b < 8; b++) if (s[b]) m[i[3:0]][8*b +: 8] = d[8*b +: 8];
    return x;
  endfunction
  function automatic exp_t model_rd(input logic [15:0] a);
    exp_t x;
    logic [12:0] i;
    i = a[15:3];
    x.resp = i < 13'd16 ? 2'b00 : 2'b10;
    x.data = i < 13'd16 ? m[i[3:0]] : 64'h0;
    x.wv = 1'b0;
    x.idx = '0;
    return x;
  endfunction
  task automatic send_wr(input logic do_a, input logic do_w, input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    logic da, dw, ra, rw;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = do_a; wvalid = do_w; da = !do_a; dw = !do_w;
    for (int n = 0; n < 50 && !(da && dw); n++) begin
      @(negedge clk);
      ra = awvalid && awready;
      rw = wvalid && wready;
      @(posedge clk); #1;
      if (ra) begin awvalid = 1'b0; da = 1'b1; end
      if (rw) begin wvalid = 1'b0; dw = 1'b1; end
    end
    chk("write_accept", {62'h0, da, dw}, 64'h3);
  endtask
  task automatic send_ar(input logic [15:0] a);
    logic da, ra;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; da = 1'b0;
    for (int n = 0; n < 50 && !da; n++) begin
      @(negedge clk);
      ra = arready;
      @(posedge clk); #1;
      if (ra) begin arvalid = 1'b0; da = 1'b1; end
    end
    chk("read_accept", {63'h0, da}, 64'h1);
  endtask
  task automatic drain();
    for (int n = 0; n < 50 && (bq.size() != 0 || rq.size() != 0); n++) @(negedge clk);
    chk("drain", 64'(bq.size() + rq.size()), 64'h0);
  endtask
  task automatic chk_reset();
    chk("rst_awready", {63'h0, awready}, 64'h0);
    chk("rst_wready", {63'h0, wready}, 64'h0);
    chk("rst_arready", {63'h0, arready}, 64'h0);
    chk("rst_bvalid", {63'h0, bvalid}, 64'h0);
    chk("rst_rvalid", {63'h0, rvalid}, 64'h0);
    chk("rst_wr_valid", {63'h0, csr_wr_valid}, 64'h0);
    chk("rst_resps", {58'h0, bresp, rresp, csr_wr_idx[1:0]}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_wr_idx", {60'h0, csr_wr_idx}, 64'h0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_csr_q[%0d]", i), csr_q[64*i +: 64], m[i]);
  endtask
  // Scoreboard monitor: samples on the falling edge, pops on each B/R handshake
  always @(negedge clk) begin
    if (reset_n) begin
      if (bvalid && !bvalid_q) begin
        if (bq.size() == 0) chk("b_unexpected", {63'h0, bvalid}, 64'h0);
        else begin
          chk("wr_valid", {63'h0, csr_wr_valid}, {63'h0, bq[0].wv});
          if (bq[0].wv) chk("wr_idx", {60'h0, csr_wr_idx}, {60'h0, bq[0].idx});
        end
      end else if (csr_wr_valid) chk("wr_valid_spurious", {63'h0, csr_wr_valid}, 64'h0);
      if (bvalid && bready && bq.size() != 0) begin
        e = bq.pop_front();
        chk("bresp", {62'h0, bresp}, {62'h0, e.resp});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", {63'h0, rvalid}, 64'h0);
        else begin
          e = rq.pop_front();
          chk("rresp", {62'h0, rresp}, {62'h0, e.resp});
          chk("rdata", rdata, e.data);
        end
      end
    end
    bvalid_q = bvalid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
  initial begin
    logic no_b;
    tbl = '{
      '{1'b0, 16'h0000, 64'h0, 8'h00, 2'b00, ID, 1'b0},
      '{1'b1, 16'h0000, 64'hFFFF, 8'hFF, 2'b00, 64'h0, 1'b0},
      '{1'b0, 16'h0000, 64'h0, 8'h00, 2'b00, ID, 1'b0},
      '{1'b1, 16'h0008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'b00, 64'h0, 1'b1},
      '{1'b0, 16'h0008, 64'h0, 8'h00, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0},
      '{1'b1, 16'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 64'h0, 1'b1},
      '{1'b1, 16'h0080, 64'h1234, 8'hFF, 2'b10, 64'h0, 1'b0},
      '{1'b0, 16'h0088, 64'h0, 8'h00, 2'b10, 64'h0, 1'b0},
      '{1'b1, 16'h000C, 64'h0, 8'h00, 2'b00, 64'h0, 1'b1},
      '{1'b0, 16'h000F, 64'h0, 8'h00, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0},
      '{1'b1, 16'h0078, 64'h0123_4567_89AB_CDEF, 8'hF0, 2'b00, 64'h0, 1'b1},
      '{1'b0, 16'h007F, 64'h0, 8'h00, 2'b00, 64'h0123_4567_0000_0000, 1'b0},
      '{1'b0, 16'h0010, 64'h0, 8'h00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}
    };
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    #1 chk("ready_before_edge", {63'h0, awready}, 64'h0);
    @(negedge clk);
    chk("awready_after_release", {63'h0, awready}, 64'h1);
    chk("wready_after_release", {63'h0, wready}, 64'h1);
    chk("arready_after_release", {63'h0, arready}, 64'h1);
    for (int k = 0; k < 13; k++) begin
      if (tbl[k].wr) begin
        void'(model_wr(tbl[k].addr, tbl[k].data, tbl[k].strb));
        bq.push_back('{tbl[k].resp, 64'h0, tbl[k].wv, tbl[k].addr[6:3]});
        send_wr(1'b1, 1'b1, tbl[k].addr, tbl[k].data, tbl[k].strb);
        @(negedge clk);
        chk($sformatf("vec%0d_b_latency", k), {63'h0, bvalid}, 64'h1);
      end else begin
        rq.push_back('{tbl[k].resp, tbl[k].rdata, 1'b0, 4'h0});
        send_ar(tbl[k].addr);
        @(negedge clk);
        chk($sformatf("vec%0d_r_latency", k), {63'h0, rvalid}, 64'h1);
      end
    end
    drain();
    chk("csr0_id", csr_q[63:0], ID);
    chk("csr1_value", csr_q[127:64], 64'hDEAD_BEEF_CAFE_F00D);
    chk("csr15_value", csr_q[1023:960], 64'h0123_4567_0000_0000);
    // W before AW
    bq.push_back(model_wr(16'h0010, 64'h1122_3344_5566_7788, 8'h0F));
    send_wr(1'b0, 1'b1, 16'h0010, 64'h1122_3344_5566_7788, 8'h0F);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("have_w_wready", {63'h0, wready}, 64'h0);
    chk("have_w_awready", {63'h0, awready}, 64'h1);
    send_wr(1'b1, 1'b0, 16'h0010, 64'h1122_3344_5566_7788, 8'h0F);
    drain();
    chk("w_first_csr2", csr_q[191:128], 64'hFFFF_FFFF_5566_7788);
    // AW before W
    bq.push_back(model_wr(16'h0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF));
    send_wr(1'b1, 1'b1, 16'h0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    bq.push_back(model_wr(16'h0020, 64'h1122_3344_5566_7788, 8'h0F));
    send_wr(1'b1, 1'b0, 16'h0020, 64'h1122_3344_5566_7788, 8'h0F);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("have_aw_awready", {63'h0, awready}, 64'h0);
    chk("have_aw_wready", {63'h0, wready}, 64'h1);
    send_wr(1'b0, 1'b1, 16'h0020, 64'h1122_3344_5566_7788, 8'h0F);
    drain();
    chk("aw_first_csr4", csr_q[319:256], 64'hFFFF_FFFF_5566_7788);
    // B backpressure with a second write waiting
    bready = 1'b0;
    bq.push_back(model_wr(16'h0028, 64'hAB, 8'hFF));
    send_wr(1'b1, 1'b1, 16'h0028, 64'hAB, 8'hFF);
    bq.push_back(model_wr(16'h0030, 64'h77, 8'hFF));
    awaddr = 16'h0030; wdata = 64'h77; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_bvalid", {63'h0, bvalid}, 64'h1);
      chk("bp_bresp", {62'h0, bresp}, 64'h0);
      chk("bp_awready", {63'h0, awready}, 64'h0);
      chk("bp_wready", {63'h0, wready}, 64'h0);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    chk("aw_held_at_b_hs", {63'h0, awready}, 64'h0);
    @(negedge clk);
    chk("awready_after_b_hs", {63'h0, awready}, 64'h1);
    chk("wready_after_b_hs", {63'h0, wready}, 64'h1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    drain();
    // R backpressure with a second read waiting
    rready = 1'b0;
    rq.push_back(model_rd(16'h0028));
    send_ar(16'h0028);
    rq.push_back(model_rd(16'h0030));
    araddr = 16'h0030; arvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_rvalid", {63'h0, rvalid}, 64'h1);
      chk("bp_rdata", rdata, 64'hAB);
      chk("bp_rresp", {62'h0, rresp}, 64'h0);
      chk("bp_arready", {63'h0, arready}, 64'h0);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(negedge clk);
    chk("ar_held_at_r_hs", {63'h0, arready}, 64'h0);
    @(negedge clk);
    chk("arready_after_r_hs", {63'h0, arready}, 64'h1);
    @(posedge clk); #1 arvalid = 1'b0;
    drain();
    // Same-cycle read and write to CSR 3
    rq.push_back(model_rd(16'h0018));
    bq.push_back(model_wr(16'h0018, 64'h5, 8'hFF));
    fork
      send_wr(1'b1, 1'b1, 16'h0018, 64'h5, 8'hFF);
      send_ar(16'h0018);
    join
    drain();
    chk("collision_csr3", csr_q[255:192], 64'h5);
    rq.push_back(model_rd(16'h0018));
    send_ar(16'h0018);
    drain();
    // Reset while holding an AW
    send_wr(1'b1, 1'b0, 16'h0020, 64'h99, 8'hFF);
    @(negedge clk);
    chk("mid_have_aw_wready", {63'h0, wready}, 64'h1);
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    no_b = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      no_b = no_b | bvalid;
    end
    chk("no_b_after_reset", {63'h0, no_b}, 64'h0);
    chk("awready_after_reset", {63'h0, awready}, 64'h1);
    chk("csr4_after_reset", csr_q[319:256], 64'h0);
    rq.push_back(model_rd(16'h0000));
    send_ar(16'h0000);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
